multi_regf: RTL and testbench
=============================

MULTI_REGF -- requirements
Module: multi_regf

Interface
REQ-001 Parameter NUM_CH, default 4, number of channels (1..16).
REQ-002 Parameter WIDTH, default 16, CTRL field width per channel (1..32).
REQ-003 Parameter CNT_W, default 8, event-counter width (1..32).
REQ-004 Parameter ADDR_W, default 13, word-address width.
REQ-005 Parameter CORE_PRIO, default 1: 1 = core write wins on collision, 0 = bus write wins.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-007 Ports (name, direction, width, meaning) SHALL be:
- main_clk_i, in, 1, clock.
- main_rst_i, in, 1, asynchronous reset, active-high.
- mem_ena_i, in, 1, bus access strobe.
- mem_addr_i, in, ADDR_W, word address.
- mem_wena_i, in, 1, 1 = write, 0 = read.
- mem_wdata_i, in, 32, write data.
- mem_rdata_o, out, 32, read data, registered.
- mem_err_o, out, 1, access error, registered.
- core_wr_i, in, NUM_CH, core write strobe per channel.
- core_wval_i, in, NUM_CH x WIDTH, core write value.
- ctrl_rval_o, out, NUM_CH x WIDTH, CTRL value to core.
- ctrl_upd_o, out, NUM_CH, update pulse after an accepted bus write.
- evt_i, in, NUM_CH, event pulse per channel.
- lock_o, out, NUM_CH, channel lock state.
- guard_o, out, 1, global write-enable guard.

Function
REQ-008 Address map, with ch = 0..NUM_CH-1:
- ch*4+0: CTRL, RW, bits [WIDTH-1:0].
- ch*4+1: STAT, read-clear, bits [CNT_W-1:0].
- ch*4+2: LOCK, write-once set, bit 0.
- NUM_CH*4: GUARD, RW, bit 0.
- All other addresses are unmapped.
REQ-009 Every bus access SHALL complete in one cycle: mem_rdata_o and mem_err_o are valid in the cycle after mem_ena_i.
- With no access, mem_rdata_o = 0 and mem_err_o = 0.
- Unused read bits return 0.
REQ-010 Access to an unmapped address SHALL return mem_rdata_o = 0 and mem_err_o = 1, with no state change.
REQ-011 A CTRL write SHALL be rejected when lock[ch] = 1 or guard = 0.
- Value unchanged, mem_err_o = 1, no ctrl_upd_o.
REQ-012 An accepted CTRL write SHALL load mem_wdata_i[WIDTH-1:0].
- ctrl_rval_o shows the new value in the next cycle.
- ctrl_upd_o[ch] pulses high for exactly that same cycle.
REQ-013 core_wr_i[ch] SHALL load core_wval_i[ch] into CTRL, ignoring lock and guard, and SHALL NOT pulse ctrl_upd_o.
REQ-014 When a core write and an accepted bus write hit the same channel in the same cycle:
- CORE_PRIO = 1: the core value is stored, the bus write is dropped, mem_err_o = 0, no ctrl_upd_o.
- CORE_PRIO = 0: the bus value is stored and ctrl_upd_o pulses.
REQ-015 The STAT counter SHALL increment on evt_i[ch] and saturate at 2^CNT_W-1.
REQ-016 A STAT read SHALL return the pre-clear value and clear the counter.
- If evt_i[ch] occurs in the same cycle, the counter becomes 1.
REQ-017 A STAT write SHALL be ignored with mem_err_o = 1.
REQ-018 LOCK write behaviour:
- wdata[0] = 1 sets lock[ch]; it stays set until reset.
- wdata[0] = 0 is ignored without error.
- A LOCK read returns lock[ch] in bit 0.
REQ-019 GUARD SHALL be freely read/written via bit 0 and drive guard_o.
REQ-020 Events on different channels and bus accesses to other channels SHALL proceed in parallel without interaction.

Reset
REQ-021 On main_rst_i = 1, asynchronously and regardless of any access in progress:
- All CTRL fields = 0.
- All counters = 0.
- lock_o = 0.
- guard_o = 1.
- mem_rdata_o = 0, mem_err_o = 0, ctrl_upd_o = 0.
REQ-022 A bus access issued in the cycle reset deasserts SHALL be processed normally.

Structure
REQ-023 Package multi_regf_pkg SHALL hold:
- Register offset constants (OFS_CTRL = 0, OFS_STAT = 1, OFS_LOCK = 2, STRIDE = 4).
- The access-decode enum type.
REQ-024 A per-channel sub-module multi_regf_chan SHALL hold CTRL, the STAT counter, the lock bit and the collision arbitration.
- It is instantiated NUM_CH times under generate.
- Bus decode, GUARD and read muxing stay in multi_regf.

Verification
REQ-025 Write ch1 CTRL = 0x1234 -> next cycle ctrl_rval_o[1] = 0x1234, ctrl_upd_o[1] = 1 for 1 cycle, mem_err_o = 0; read back gives 0x00001234.
REQ-026 Write ch0 LOCK = 1, then CTRL = 0x00FF -> mem_err_o = 1, CTRL unchanged; write LOCK = 0 -> lock_o[0] stays 1, mem_err_o = 0.
REQ-027 CNT_W = 4: apply 20 evt_i[2] pulses -> STAT read = 15; read again with simultaneous evt_i[2] -> returns 0, next read returns 1.
REQ-028 CORE_PRIO = 1: core_wr_i[3] with 0xAAAA plus same-cycle bus write 0x5555 -> CTRL = 0xAAAA, no ctrl_upd_o; repeat with CORE_PRIO = 0 -> CTRL = 0x5555, ctrl_upd_o pulses.
REQ-029 GUARD = 0, then bus CTRL write -> mem_err_o = 1; read address NUM_CH*4+1 -> rdata 0, mem_err_o = 1.
REQ-030 Assert main_rst_i mid-sequence (lock set, counter 7) -> all outputs at reset values immediately; guard_o = 1.

Source files
------------

// File: rtl/multi_regf_pkg.sv
// Shared register-map constants and the bus access decode type for the
// multi-channel register file.
package multi_regf_pkg;

   localparam logic [1:0] OFS_CTRL = 2'd0;
   localparam logic [1:0] OFS_STAT = 2'd1;
   localparam logic [1:0] OFS_LOCK = 2'd2;
   localparam int         STRIDE   = 4;

   typedef enum logic [2:0] {
      ACC_NONE,
      ACC_CTRL,
      ACC_STAT,
      ACC_LOCK,
      ACC_GUARD,
      ACC_UNMAPPED
   } acc_e;

endpackage

// File: rtl/multi_regf_chan.sv
// One channel: CTRL field, saturating STAT event counter and write-once lock.
// The bus write arriving here has already passed the lock/guard checks.
module multi_regf_chan #(
   parameter int WIDTH     = 16,
   parameter int CNT_W     = 8,
   parameter int CORE_PRIO = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             core_wr,
   input  logic [WIDTH-1:0] core_wval,
   input  logic             bus_we,
   input  logic [WIDTH-1:0] bus_wdata,
   input  logic             stat_rd,
   input  logic             lock_set,
   input  logic             evt,
   output logic [WIDTH-1:0] ctrl,
   output logic [CNT_W-1:0] cnt,
   output logic             lock,
   output logic             upd
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // A colliding core write either shadows the bus write or loses to it;
   // the update pulse only reports values that actually came from the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl <= '0;
         upd  <= 1'b0;
      end else begin
         upd <= 1'b0;
         if (core_wr && (CORE_PRIO != 0 || !bus_we)) begin
            ctrl <= core_wval;
         end else if (bus_we) begin
            ctrl <= bus_wdata;
            upd  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (stat_rd) begin
         cnt <= evt ? CNT_ONE : '0;
      end else if (evt && cnt != CNT_MAX) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock <= 1'b0;
      end else if (lock_set) begin
         lock <= 1'b1;
      end
   end

endmodule

// File: rtl/multi_regf.sv
// Multi-channel register file: bus decode, global write guard and the
// registered read path around NUM_CH channel slices.
module multi_regf
   import multi_regf_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int WIDTH     = 16,
   parameter int CNT_W     = 8,
   parameter int ADDR_W    = 13,
   parameter int CORE_PRIO = 1
) (
   input  logic                    main_clk_i,
   input  logic                    main_rst_i,
   input  logic                    mem_ena_i,
   input  logic [ADDR_W-1:0]       mem_addr_i,
   input  logic                    mem_wena_i,
   input  logic [31:0]             mem_wdata_i,
   output logic [31:0]             mem_rdata_o,
   output logic                    mem_err_o,
   input  logic [NUM_CH-1:0]       core_wr_i,
   input  logic [NUM_CH*WIDTH-1:0] core_wval_i,
   output logic [NUM_CH*WIDTH-1:0] ctrl_rval_o,
   output logic [NUM_CH-1:0]       ctrl_upd_o,
   input  logic [NUM_CH-1:0]       evt_i,
   output logic [NUM_CH-1:0]       lock_o,
   output logic                    guard_o
);

   localparam int                CH_W       = ADDR_W - 2;
   localparam logic [ADDR_W-1:0] GUARD_ADDR = ADDR_W'(NUM_CH * STRIDE);
   localparam logic [CH_W-1:0]   CH_LIMIT   = CH_W'(NUM_CH);

   logic [CH_W-1:0]   addr_ch;
   logic [1:0]        addr_ofs;
   acc_e              acc;
   logic [NUM_CH-1:0] ch_sel;
   logic [NUM_CH-1:0] lock_vec;
   logic [NUM_CH-1:0] upd_vec;
   logic [NUM_CH-1:0] bus_we;
   logic [NUM_CH-1:0] stat_rd;
   logic [NUM_CH-1:0] lock_set;
   logic [WIDTH-1:0]  ctrl_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_q  [NUM_CH];
   logic              guard_q;
   logic              sel_locked;
   logic              ctrl_accept;
   logic [31:0]       rdata_d;
   logic              err_d;

   assign addr_ch  = mem_addr_i[ADDR_W-1:2];
   assign addr_ofs = mem_addr_i[1:0];

   always_comb begin
      acc = ACC_NONE;
      if (mem_ena_i) begin
         if (mem_addr_i == GUARD_ADDR) begin
            acc = ACC_GUARD;
         end else if (addr_ch < CH_LIMIT) begin
            case (addr_ofs)
               OFS_CTRL: acc = ACC_CTRL;
               OFS_STAT: acc = ACC_STAT;
               OFS_LOCK: acc = ACC_LOCK;
               default:  acc = ACC_UNMAPPED;
            endcase
         end else begin
            acc = ACC_UNMAPPED;
         end
      end
   end

   always_comb begin
      ch_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_sel[i] = (addr_ch == CH_W'(i));
      end
   end

   assign sel_locked  = |(ch_sel & lock_vec);
   assign ctrl_accept = (acc == ACC_CTRL) && mem_wena_i && guard_q && !sel_locked;
   assign bus_we      = ctrl_accept ? ch_sel : '0;
   assign stat_rd     = (acc == ACC_STAT && !mem_wena_i) ? ch_sel : '0;
   assign lock_set    = (acc == ACC_LOCK && mem_wena_i && mem_wdata_i[0]) ? ch_sel : '0;

   // Writes return zero data; only rejected or illegal accesses raise err.
   always_comb begin
      rdata_d = '0;
      err_d   = 1'b0;
      case (acc)
         ACC_CTRL: begin
            if (mem_wena_i) begin
               err_d = !ctrl_accept;
            end else begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (ch_sel[i]) rdata_d[WIDTH-1:0] = ctrl_q[i];
               end
            end
         end
         ACC_STAT: begin
            if (mem_wena_i) begin
               err_d = 1'b1;
            end else begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (ch_sel[i]) rdata_d[CNT_W-1:0] = cnt_q[i];
               end
            end
         end
         ACC_LOCK:     if (!mem_wena_i) rdata_d[0] = sel_locked;
         ACC_GUARD:    if (!mem_wena_i) rdata_d[0] = guard_q;
         ACC_UNMAPPED: err_d = 1'b1;
         default:      ;
      endcase
   end

   always_ff @(posedge main_clk_i or posedge main_rst_i) begin
      if (main_rst_i) begin
         mem_rdata_o <= '0;
         mem_err_o   <= 1'b0;
         guard_q     <= 1'b1;
      end else begin
         mem_rdata_o <= rdata_d;
         mem_err_o   <= err_d;
         if (acc == ACC_GUARD && mem_wena_i) guard_q <= mem_wdata_i[0];
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      multi_regf_chan #(
         .WIDTH     (WIDTH),
         .CNT_W     (CNT_W),
         .CORE_PRIO (CORE_PRIO)
      ) u_chan (
         .clk       (main_clk_i),
         .rst       (main_rst_i),
         .core_wr   (core_wr_i[g]),
         .core_wval (core_wval_i[g*WIDTH +: WIDTH]),
         .bus_we    (bus_we[g]),
         .bus_wdata (mem_wdata_i[WIDTH-1:0]),
         .stat_rd   (stat_rd[g]),
         .lock_set  (lock_set[g]),
         .evt       (evt_i[g]),
         .ctrl      (ctrl_q[g]),
         .cnt       (cnt_q[g]),
         .lock      (lock_vec[g]),
         .upd       (upd_vec[g])
      );
      assign ctrl_rval_o[g*WIDTH +: WIDTH] = ctrl_q[g];
   end

   assign lock_o     = lock_vec;
   assign ctrl_upd_o = upd_vec;
   assign guard_o    = guard_q;

endmodule

// File: tb/tb_multi_regf.sv
// Two register files (core-priority and bus-priority) driven with identical
// directed and random traffic, compared against a register-map level model.
module tb_multi_regf;

   localparam int NUM_CH     = 4;
   localparam int WIDTH      = 16;
   localparam int CNT_W      = 4;
   localparam int ADDR_W     = 13;
   localparam int CNT_MAX    = 15;
   localparam int GUARD_ADDR = 16;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    ena;
   logic [ADDR_W-1:0]       addr;
   logic                    wena;
   logic [31:0]             wdata;
   logic [NUM_CH-1:0]       core_wr;
   logic [NUM_CH*WIDTH-1:0] core_wval;
   logic [NUM_CH-1:0]       evt;

   logic [31:0]             rdata_a, rdata_b;
   logic                    err_a, err_b;
   logic [NUM_CH*WIDTH-1:0] ctrl_a, ctrl_b;
   logic [NUM_CH-1:0]       upd_a, upd_b;
   logic [NUM_CH-1:0]       lock_a, lock_b;
   logic                    guard_a, guard_b;

   // Model state per instance: index 0 = core priority, 1 = bus priority.
   logic [WIDTH-1:0] m_ctrl  [2][NUM_CH];
   int               m_cnt   [2][NUM_CH];
   bit               m_lock  [2][NUM_CH];
   bit               m_guard [2];
   logic [31:0]      e_rd    [2];
   bit               e_err   [2];
   logic [NUM_CH-1:0] e_upd  [2];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multi_regf #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .CORE_PRIO(1)) u_dut_a (
      .main_clk_i(clk), .main_rst_i(rst), .mem_ena_i(ena), .mem_addr_i(addr),
      .mem_wena_i(wena), .mem_wdata_i(wdata), .mem_rdata_o(rdata_a), .mem_err_o(err_a),
      .core_wr_i(core_wr), .core_wval_i(core_wval), .ctrl_rval_o(ctrl_a),
      .ctrl_upd_o(upd_a), .evt_i(evt), .lock_o(lock_a), .guard_o(guard_a)
   );

   multi_regf #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .CORE_PRIO(0)) u_dut_b (
      .main_clk_i(clk), .main_rst_i(rst), .mem_ena_i(ena), .mem_addr_i(addr),
      .mem_wena_i(wena), .mem_wdata_i(wdata), .mem_rdata_o(rdata_b), .mem_err_o(err_b),
      .core_wr_i(core_wr), .core_wval_i(core_wval), .ctrl_rval_o(ctrl_b),
      .ctrl_upd_o(upd_b), .evt_i(evt), .lock_o(lock_b), .guard_o(guard_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      ena = 1'b0; addr = '0; wena = 1'b0; wdata = '0;
      core_wr = '0; core_wval = '0; evt = '0;
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_ctrl[d][c] = '0; m_cnt[d][c] = 0; m_lock[d][c] = 1'b0;
         end
         m_guard[d] = 1'b1; e_rd[d] = '0; e_err[d] = 1'b0; e_upd[d] = '0;
      end
   endtask

   // Applies one clock worth of the current inputs to the register-map model.
   task automatic model_update();
      int ch, ofs, acc_ch, rd_ch;
      for (int d = 0; d < 2; d++) begin
         ch = int'(addr) / 4; ofs = int'(addr) % 4; acc_ch = -1; rd_ch = -1;
         e_rd[d] = '0; e_err[d] = 1'b0; e_upd[d] = '0;
         if (ena) begin
            if (int'(addr) == GUARD_ADDR) begin
               if (wena) m_guard[d] = wdata[0];
               else      e_rd[d] = 32'(m_guard[d]);
            end else if (ch < NUM_CH && ofs != 3) begin
               case (ofs)
                  0: if (wena) begin
                        if (!m_lock[d][ch] && m_guard[d]) acc_ch = ch;
                        else e_err[d] = 1'b1;
                     end else e_rd[d] = 32'(m_ctrl[d][ch]);
                  1: if (wena) e_err[d] = 1'b1;
                     else begin e_rd[d] = 32'(m_cnt[d][ch]); rd_ch = ch; end
                  default: if (wena) begin
                        if (wdata[0]) m_lock[d][ch] = 1'b1;
                     end else e_rd[d] = 32'(m_lock[d][ch]);
               endcase
            end else begin
               e_err[d] = 1'b1;
            end
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (core_wr[c] && (d == 0 || acc_ch != c)) begin
               m_ctrl[d][c] = core_wval[c*WIDTH +: WIDTH];
            end else if (acc_ch == c) begin
               m_ctrl[d][c] = wdata[WIDTH-1:0];
               e_upd[d][c] = 1'b1;
            end
            if (rd_ch == c)      m_cnt[d][c] = evt[c] ? 1 : 0;
            else if (evt[c])     m_cnt[d][c] = (m_cnt[d][c] < CNT_MAX) ? m_cnt[d][c] + 1 : CNT_MAX;
         end
      end
   endtask

   task automatic check_output();
      logic [63:0] exp_ctrl;
      logic [3:0]  exp_lock;
      string       p;
      for (int d = 0; d < 2; d++) begin
         p = (d == 0) ? "prio_core" : "prio_bus";
         for (int c = 0; c < NUM_CH; c++) begin
            exp_ctrl[c*WIDTH +: WIDTH] = m_ctrl[d][c];
            exp_lock[c] = m_lock[d][c];
         end
         check({p, ".rdata"}, (d == 0) ? rdata_a : rdata_b, e_rd[d]);
         check({p, ".err"},   (d == 0) ? err_a   : err_b,   e_err[d]);
         check({p, ".ctrl"},  (d == 0) ? ctrl_a  : ctrl_b,  exp_ctrl);
         check({p, ".upd"},   (d == 0) ? upd_a   : upd_b,   e_upd[d]);
         check({p, ".lock"},  (d == 0) ? lock_a  : lock_b,  exp_lock);
         check({p, ".guard"}, (d == 0) ? guard_a : guard_b, m_guard[d]);
      end
   endtask

   task automatic apply_stimulus();
      model_update();
      @(posedge clk);
      #1;
      check_output();
      idle_inputs();
   endtask

   task automatic bus_wr(input int a, input logic [31:0] dat);
      ena = 1'b1; wena = 1'b1; addr = ADDR_W'(a); wdata = dat;
      apply_stimulus();
   endtask

   task automatic bus_rd(input int a);
      ena = 1'b1; wena = 1'b0; addr = ADDR_W'(a);
      apply_stimulus();
   endtask

   initial begin
      int r;
      rst = 1'b1;
      idle_inputs();
      model_reset();
      #12;
      check_output();

      // Release reset together with an access that must still be processed.
      @(posedge clk); #1;
      rst = 1'b0;
      bus_wr(4, 32'h0000_1234);
      check("dir.ctrl1_new", ctrl_a[31:16], 16'h1234);
      check("dir.upd1_pulse", upd_a[1], 1'b1);
      bus_rd(4);
      check("dir.ctrl1_readback", rdata_a, 32'h0000_1234);
      check("dir.upd1_single", upd_a[1], 1'b0);

      bus_wr(2, 32'h1);
      bus_wr(0, 32'h0000_00FF);
      check("dir.locked_write_err", err_a, 1'b1);
      bus_wr(2, 32'h0);
      check("dir.lock_sticky", lock_a[0], 1'b1);

      repeat (20) begin evt = 4'b0100; apply_stimulus(); end
      bus_rd(9);
      check("dir.stat_saturated", rdata_a, 32'd15);
      evt = 4'b0100;
      bus_rd(9);
      check("dir.stat_cleared", rdata_a, 32'd0);
      bus_rd(9);
      check("dir.stat_evt_on_clear", rdata_a, 32'd1);

      core_wr = 4'b1000; core_wval[63:48] = 16'hAAAA;
      bus_wr(12, 32'h0000_5555);
      check("dir.coll_core_val", ctrl_a[63:48], 16'hAAAA);
      check("dir.coll_bus_val", ctrl_b[63:48], 16'h5555);
      check("dir.coll_bus_upd", upd_b[3], 1'b1);

      bus_wr(GUARD_ADDR, 32'h0);
      bus_wr(4, 32'h0000_7777);
      check("dir.guard_block_err", err_a, 1'b1);
      bus_rd(GUARD_ADDR + 1);
      check("dir.unmapped_err", err_a, 1'b1);
      bus_wr(GUARD_ADDR, 32'h1);

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 19);
         ena = ($urandom_range(0, 9) < 7);
         wena = $urandom_range(0, 1);
         wdata = $urandom;
         if (r < 16)      addr = ADDR_W'(r);
         else if (r < 18) addr = ADDR_W'(GUARD_ADDR);
         else             addr = ADDR_W'($urandom_range(GUARD_ADDR + 1, 8191));
         if (r < 16 && r % 4 == 2) wdata[0] = ($urandom_range(0, 15) == 0);
         if (r == 16 || r == 17)   wdata[0] = ($urandom_range(0, 3) != 0);
         evt = 4'($urandom);
         for (int c = 0; c < NUM_CH; c++) core_wr[c] = ($urandom_range(0, 7) == 0);
         core_wval = {$urandom, $urandom};
         apply_stimulus();
      end

      // Build up state, then reset asynchronously between clock edges.
      bus_wr(GUARD_ADDR, 32'h1);
      bus_wr(2, 32'h1);
      bus_rd(5);
      repeat (7) begin evt = 4'b0010; apply_stimulus(); end
      core_wr = 4'b0100; core_wval[47:32] = 16'hBEEF;
      apply_stimulus();
      bus_rd(8);
      check("dir.pre_reset_rdata", rdata_a, 32'h0000_BEEF);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_output();
      @(posedge clk); #1;
      rst = 1'b0;
      bus_rd(5);
      bus_rd(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
